// File: rtl/iter_mult.sv
// iter_mult -- iterative shift-and-add multiplier, one partial product per clock.
//
// Handshake: start is a request sampled on every rising edge while the block
// is in IDLE or DONE; it is ignored in RUN. result_rdy is a one-cycle
// completion pulse with no back-pressure. result and overflow stay stable
// from that pulse until the next completion or reset. busy is high in RUN
// and in DONE.
//
// Timing: a start sampled at edge k enters RUN, and WIDTH RUN cycles follow.
// The final partial product is added on edge k+WIDTH, which also enters DONE.
// result_rdy is therefore high in the cycle that a consumer captures on edge
// k+WIDTH+1. When start is held high, the DONE cycle accepts it directly, so
// there is one operation every WIDTH+1 cycles.
//
// Signed mode multiplies magnitudes and negates the final product when the
// operand signs differ. The magnitude of the most-negative value,
// 2^(WIDTH-1), still fits in WIDTH unsigned bits.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   start       multiply request
//   is_signed   1 = two's-complement operands, 0 = unsigned
//   data_a      multiplicand, WIDTH bits
//   data_b      multiplier, WIDTH bits
//   result      product, 2*WIDTH bits, held between completions
//   result_rdy  one-cycle pulse, high in the DONE cycle
//   busy        high in RUN and DONE
//   overflow    product does not fit in WIDTH bits of the selected signedness
//   dbg_state   current FSM state (0 IDLE, 1 RUN, 2 DONE)
module iter_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_rdy,
  output logic                 busy,
  output logic                 overflow,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic              neg;
  logic              sgn;
  logic [PW-1:0]     acc;

  logic [WIDTH-1:0]  a_abs;
  logic [WIDTH-1:0]  b_abs;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     acc_next;
  logic [PW-1:0]     prod_final;
  logic              ovf_final;
  logic              last_iter;

  always_comb begin
    a_abs = data_a;
    b_abs = data_b;
    if (is_signed && data_a[WIDTH-1]) a_abs = ~data_a + WIDTH'(1);
    if (is_signed && data_b[WIDTH-1]) b_abs = ~data_b + WIDTH'(1);

    // a_mag AND b_mag[cnt], weighted by 2^cnt
    pp       = {{WIDTH{1'b0}}, a_mag & {WIDTH{b_mag[cnt]}}} << cnt;
    acc_next = acc + pp;

    prod_final = acc_next;
    if (neg) prod_final = ~acc_next + PW'(1);

    // Signed: the upper WIDTH+1 bits must all be sign copies.
    // Unsigned: the upper WIDTH bits must all be zero.
    if (sgn) begin
      ovf_final = !((&prod_final[PW-1:WIDTH-1]) || !(|prod_final[PW-1:WIDTH-1]));
    end else begin
      ovf_final = |prod_final[PW-1:WIDTH];
    end

    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      neg        <= 1'b0;
      sgn        <= 1'b0;
      acc        <= '0;
      result     <= '0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
        IDLE, DONE: begin
          result_rdy <= 1'b0;
          if (start) begin
            a_mag <= a_abs;
            b_mag <= b_abs;
            sgn   <= is_signed;
            neg   <= is_signed & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            result     <= prod_final;
            overflow   <= ovf_final;
            result_rdy <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          result_rdy <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_iter_mult.sv
// tb_iter_mult -- self-checking bench for iter_mult at WIDTH=4 and WIDTH=16.
// Expected {overflow, result} values come from an integer reference model.
// They are queued when an operation is issued and compared when result_rdy
// pulses.
module tb_iter_mult;

  logic clock;
  logic reset;

  // WIDTH=4 instance
  logic        start4, sgn4;
  logic [3:0]  a4, b4;
  logic [7:0]  res4;
  logic        rdy4, busy4, ovf4;
  logic [1:0]  st4;

  // WIDTH=16 instance
  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic [31:0] res16;
  logic        rdy16, busy16, ovf16;
  logic [1:0]  st16;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp4_q[$];
  logic [32:0] exp16_q[$];
  logic [8:0]  e4;
  logic [32:0] e16;

  iter_mult #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .is_signed(sgn4),
    .data_a(a4), .data_b(b4), .result(res4), .result_rdy(rdy4),
    .busy(busy4), .overflow(ovf4), .dbg_state(st4)
  );

  iter_mult #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .is_signed(sgn16),
    .data_a(a16), .data_b(b16), .result(res16), .result_rdy(rdy16),
    .busy(busy16), .overflow(ovf16), .dbg_state(st16)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: {overflow, 64-bit product truncated to 2w bits}
  function automatic logic [64:0] model(input int w, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    longint ea, eb, p, lim;
    logic [63:0] pm;
    logic ovf;
    ea = longint'(a);
    eb = longint'(b);
    if (s && a[w-1]) ea = ea - (longint'(1) << w);
    if (s && b[w-1]) eb = eb - (longint'(1) << w);
    p  = ea * eb;
    pm = 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    if (s) begin
      lim = longint'(1) << (w - 1);
      ovf = (p >= lim) || (p < -lim);
    end else begin
      ovf = (p >= (longint'(1) << w));
    end
    return {ovf, pm};
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clock) begin
    if (!reset && rdy4) begin
      if (exp4_q.size() == 0) begin
        chk("rdy4_unexpected", 64'(rdy4), 64'd0);
      end else begin
        e4 = exp4_q.pop_front();
        chk("res4", 64'(res4), 64'(e4[7:0]));
        chk("ovf4", 64'(ovf4), 64'(e4[8]));
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && rdy16) begin
      if (exp16_q.size() == 0) begin
        chk("rdy16_unexpected", 64'(rdy16), 64'd0);
      end else begin
        e16 = exp16_q.pop_front();
        chk("res16", 64'(res16), 64'(e16[31:0]));
        chk("ovf16", 64'(ovf16), 64'(e16[32]));
      end
    end
  end

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic push4(input logic s, input logic [3:0] a, input logic [3:0] b);
    logic [64:0] m;
    m = model(4, s, {28'b0, a}, {28'b0, b});
    exp4_q.push_back({m[64], m[7:0]});
  endtask

  task automatic drain4();
    for (int i = 0; i < 20 && (exp4_q.size() != 0 || busy4); i++) @(negedge clock);
    chk("drain4", {62'b0, exp4_q.size() != 0, busy4}, 64'd0);
  endtask

  task automatic issue4(input logic s, input logic [3:0] a, input logic [3:0] b);
    sgn4 = s; a4 = a; b4 = b; start4 = 1'b1;
    push4(s, a, b);
    @(posedge clock); @(negedge clock);
    // scramble inputs while the operation runs
    start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15));
    b4 = 4'($urandom_range(0, 15));
    sgn4 = 1'($urandom_range(0, 1));
    chk("busy4_run", 64'(busy4), 64'd1);
    drain4();
  endtask

  task automatic issue16(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [64:0] m;
    sgn16 = s; a16 = a; b16 = b; start16 = 1'b1;
    m = model(16, s, {16'b0, a}, {16'b0, b});
    exp16_q.push_back({m[64], m[31:0]});
    @(posedge clock); @(negedge clock);
    start16 = 1'b0;
    a16 = 16'($urandom());
    b16 = 16'($urandom());
    sgn16 = 1'($urandom_range(0, 1));
    for (int i = 0; i < 40 && (exp16_q.size() != 0 || busy16); i++) @(negedge clock);
    chk("drain16", {62'b0, exp16_q.size() != 0, busy16}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start4 = 0; sgn4 = 0; a4 = 0; b4 = 0;
    start16 = 0; sgn16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clock);

    // outputs during reset
    chk("rst_res4",  64'(res4),  64'd0);
    chk("rst_rdy4",  64'(rdy4),  64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_ovf4",  64'(ovf4),  64'd0);
    chk("rst_st4",   64'(st4),   64'd0);
    chk("rst_res16", 64'(res16), 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);

    // the first start right after reset release is accepted on the next edge
    reset = 1'b0;
    sgn4 = 0; a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
    push4(0, 4'hF, 4'hF);
    @(posedge clock); @(negedge clock);   // after accept edge e0
    start4 = 1'b0;
    chk("lat_st_run", 64'(st4), 64'd1);
    // rdy is high after edge e0+4, i.e. captured on edge e0+5
    for (int i = 1; i <= 5; i++) begin
      @(posedge clock); @(negedge clock);
      chk($sformatf("lat_rdy%0d", i), 64'(rdy4), 64'(i == 4));
      chk($sformatf("lat_busy%0d", i), 64'(busy4), 64'(i <= 4));
    end
    chk("lat_res_hold", 64'(res4), 64'hE1);
    chk("lat_ovf_hold", 64'(ovf4), 64'd1);

    // signed corner cases
    issue4(1, 4'h8, 4'h8);
    issue4(1, 4'hE, 4'h3);
    issue4(1, 4'h7, 4'h8);
    issue4(0, 4'h0, 4'hF);

    // start held high with new operands every cycle: only the operands on the
    // accept edges (i = 0, 5, 10) count; the pulses show at i = 5, 10, 15
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) chk($sformatf("b2b_rdy%0d", i), 64'(rdy4), 64'((i % 5) == 0 && i <= 15));
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      sgn4 = 1'($urandom_range(0, 1));
      start4 = (i < 15);
      if ((i % 5) == 0 && i <= 10) push4(sgn4, a4, b4);
      @(posedge clock); @(negedge clock);
    end
    start4 = 1'b0;
    drain4();

    // reset in the middle of RUN
    issue4(1, 4'hE, 4'h3);                // leaves a non-zero result
    sgn4 = 0; a4 = 4'hB; b4 = 4'hD; start4 = 1'b1;
    push4(0, 4'hB, 4'hD);
    @(posedge clock); @(negedge clock);
    start4 = 1'b0;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    chk("abort_st_run", 64'(st4), 64'd1);
    #2 reset = 1'b1;
    exp4_q.delete();
    #1;
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_res",  64'(res4),  64'd0);
    chk("abort_ovf",  64'(ovf4),  64'd0);
    chk("abort_st",   64'(st4),   64'd0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_rdy", 64'(rdy4), 64'd0);
      @(negedge clock);
    end
    issue4(0, 4'h9, 4'h6);

    // exhaustive WIDTH=4 sweep in both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          issue4(1'(s), 4'(a), 4'(b));

    // WIDTH=16 corners, then random operations
    issue16(1, 16'h8000, 16'h8000);
    issue16(0, 16'hFFFF, 16'hFFFF);
    issue16(1, 16'hFFFF, 16'h8000);
    issue16(1, 16'h7FFF, 16'h0001);
    for (int n = 0; n < 2000; n++)
      issue16(1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
